sram_banked_array: RTL and testbench
====================================

# sram_banked_array

Parametrised, multi-bank successor to the mixed-signal cell array. It holds ROWS×COLS bits per bank across BANKS banks and accepts digital read/write requests. Each access is sequenced through precharge, wordline and sense/drive phases, and real-valued wordline and bitline voltages are published for the analog views. It sits between the digital memory controller and the analog bitline/sense-amp models.

## Interface
- ROWS, 16, rows per bank; power of two, ≥2
- COLS, 8, bits per word (columns)
- BANKS, 2, number of banks; power of two, ≥2
- VDD, 1.5, supply level (real)
- VSS, 0.0, ground level (real)
- VTH, 0.8, sense threshold (real)
- Derived: RW = $clog2(ROWS), BW = $clog2(BANKS), AW = BW+RW
- Clocking: one clock; reset is asynchronous and active-low.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  access request
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  AW  {bank, row}; bank = addr[AW-1:RW]
- wdata  in  COLS  write data
- ready  out  1  block idle, can accept a request
- rvalid  out  1  one-cycle pulse: rdata is new
- rdata  out  COLS  last read word, held until next read completes
- bank_sel  out  BANKS  one-hot active bank, 0 when idle
- row_wr_v  out  real[0:ROWS-1]  write wordlines of active bank
- row_rd_v  out  real[0:ROWS-1]  read wordlines of active bank
- bl_v, blb_v  out  real[0:COLS-1]  bitline / complement voltages

## Operation
- Storage: BANKS×ROWS×COLS bits, all cleared to 0 by reset.
- FSM states: IDLE, PRECH, RWL, SENSE, WDRIVE, WWL.
- IDLE: ready=1. req=1 latches we, addr and wdata. The FSM then moves to PRECH if we=0, or to WDRIVE if we=1. req with ready=0 cannot occur, because ready=0 outside IDLE and requests are ignored there.
- PRECH: bl_v = blb_v = VDD on all columns. Next state is RWL.
- RWL: row_rd_v[row] = VDD and all other rows = VSS. For each column c, if the stored bit is 1, bl_v[c] = VDD and blb_v[c] = VDD/2. If the stored bit is 0, bl_v[c] = VDD/2 and blb_v[c] = VDD. Next state is SENSE.
- SENSE: bitlines hold their RWL values. rdata[c] is captured as (bl_v[c] > VTH) and rvalid=1 for that cycle. Next state is IDLE.
- WDRIVE: bl_v[c] = wdata[c] ? VDD : VSS and blb_v[c] is the complement. Next state is WWL.
- WWL: the bitlines stay driven and row_wr_v[row] = VDD. The latched word is written into storage on the clock edge that leaves WWL. Next state is IDLE.
- bank_sel = one-hot of the latched bank in every non-IDLE state.
- IDLE outputs: every wordline = VSS and every bitline = VDD, i.e. idle is precharged.
- Banks are fully independent. A write to one bank never alters another bank.

## Timing
- Reset (async assert) values: state=IDLE, ready=1, rvalid=0, rdata=0, bank_sel=0, all row_*_v=VSS, all bl_v/blb_v=VDD, storage all 0.
- The request is accepted at edge T0. Read: PRECH runs T0–T1, RWL T1–T2, SENSE T2–T3 (rvalid high), and ready returns after T3. Read latency is 3 cycles and throughput is one read per 4 cycles.
- Write: WDRIVE runs T0–T1 and WWL T1–T2. Storage updates at T2 and ready returns after T2. Write cost is 3 cycles including the IDLE cycle.
- rvalid is a single-cycle pulse that is never asserted on writes. rdata changes only at the edge that enters SENSE.
- Read-after-write to the same address returns the new data, because the write commits before the FSM returns to IDLE.
- Reset mid-operation: the FSM returns to IDLE immediately and all outputs take their reset values.
  - Reset in WDRIVE or WWL leaves the word uncommitted.
  - Reset in SENSE drops rvalid with no further pulse.
- All real outputs are registered or decoded from registered state only. They are never combinational from req.

## Test plan
- Reset then read addr 0 → rvalid at 3rd edge after accept with rdata=0; bl_v=0.75 and blb_v=1.5 on all columns during RWL.
- Write 0xA5 to {bank1,row3}, then read it → rdata=0xA5. During WDRIVE, bl_v = [1.5,0,1.5,0,0,1.5,0,1.5] (MSB first) and blb_v is the complement.
- Write 0xFF to {bank0,row3}, then read {bank1,row3} → still 0xA5. bank_sel = 2'b01 during the write and 2'b10 during the read.
- Back-to-back: hold req high continuously with alternating we → a request is accepted only in IDLE cycles and none is lost or duplicated versus the scoreboard.
- Assert rst_n=0 during WWL of a write of 0x3C to row 5 → outputs are at reset values within the same cycle, and a subsequent read of row 5 returns 0x00.
- Check wordline exclusivity across all ROWS → exactly one row_rd_v or row_wr_v equals VDD in RWL or WWL, and none in the other states.

Source files
------------

// File: rtl/sram_banked_array.sv
// ============================================================================
// sram_banked_array
// Multi-bank SRAM array. Each access is sequenced through precharge, wordline
// and sense/drive phases, and real-valued wordline/bitline voltages are
// published for the analog views.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_banked_array #(
  parameter int  ROWS  = 16,
  parameter int  COLS  = 8,
  parameter int  BANKS = 2,
  parameter real VDD   = 1.5,
  parameter real VSS   = 0.0,
  parameter real VTH   = 0.8,
  localparam int RW    = $clog2(ROWS),
  localparam int BW    = $clog2(BANKS),
  localparam int AW    = BW + RW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [COLS-1:0] wdata,
  output logic            ready,
  output logic            rvalid,
  output logic [COLS-1:0] rdata,
  output logic [BANKS-1:0] bank_sel,
  output real             row_wr_v [0:ROWS-1],
  output real             row_rd_v [0:ROWS-1],
  output real             bl_v     [0:COLS-1],
  output real             blb_v    [0:COLS-1]
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRECH  = 3'd1,
    S_RWL    = 3'd2,
    S_SENSE  = 3'd3,
    S_WDRIVE = 3'd4,
    S_WWL    = 3'd5
  } state_t;

  // The sense amp resolves each column by comparing bl_v against VTH; with
  // constant supply levels both outcomes fold to constants at elaboration.
  localparam logic SENSE_HI = (VDD > VTH);
  localparam logic SENSE_LO = ((VDD / 2.0) > VTH);

  state_t          state;
  logic [RW-1:0]   lat_row;
  logic [BW-1:0]   lat_bank;
  logic [COLS-1:0] lat_wdata;
  logic [COLS-1:0] mem [0:BANKS*ROWS-1];
  logic [COLS-1:0] rd_word;
  logic [COLS-1:0] sense_word;

  assign rd_word    = mem[{lat_bank, lat_row}];
  assign sense_word = (rd_word & {COLS{SENSE_HI}}) | (~rd_word & {COLS{SENSE_LO}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lat_row   <= '0;
      lat_bank  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
      for (int i = 0; i < BANKS*ROWS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_row   <= addr[RW-1:0];
            lat_bank  <= addr[AW-1:RW];
            lat_wdata <= wdata;
            state     <= we ? S_WDRIVE : S_PRECH;
          end
        end
        S_PRECH:  state <= S_RWL;
        S_RWL: begin
          rdata <= sense_word;
          state <= S_SENSE;
        end
        S_SENSE:  state <= S_IDLE;
        S_WDRIVE: state <= S_WWL;
        S_WWL: begin
          mem[{lat_bank, lat_row}] <= lat_wdata;
          state <= S_IDLE;
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign ready    = (state == S_IDLE);
  assign rvalid   = (state == S_SENSE);
  assign bank_sel = (state == S_IDLE) ? '0 : (BANKS'(1) << lat_bank);

  // Analog views are decoded purely from registered state, never from req.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      row_wr_v[r] = VSS;
      row_rd_v[r] = VSS;
    end
    for (int c = 0; c < COLS; c++) begin
      bl_v[c]  = VDD;
      blb_v[c] = VDD;
    end
    case (state)
      S_RWL, S_SENSE: begin
        if (state == S_RWL) begin
          row_rd_v[lat_row] = VDD;
        end
        for (int c = 0; c < COLS; c++) begin
          bl_v[c]  = rd_word[c] ? VDD : (VDD / 2.0);
          blb_v[c] = rd_word[c] ? (VDD / 2.0) : VDD;
        end
      end
      S_WDRIVE, S_WWL: begin
        if (state == S_WWL) begin
          row_wr_v[lat_row] = VDD;
        end
        for (int c = 0; c < COLS; c++) begin
          bl_v[c]  = lat_wdata[c] ? VDD : VSS;
          blb_v[c] = lat_wdata[c] ? VSS : VDD;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_banked_array.sv
// ============================================================================
// tb_sram_banked_array
// Directed self-checking bench for sram_banked_array (default parameters).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_banked_array;

  localparam real V_HI   = 1.5;
  localparam real V_HALF = 0.75;
  localparam real V_LO   = 0.0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic       we;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       rvalid;
  logic [7:0] rdata;
  logic [1:0] bank_sel;
  real        row_wr_v [0:15];
  real        row_rd_v [0:15];
  real        bl_v     [0:7];
  real        blb_v    [0:7];

  int total = 0;
  int bad   = 0;

  sram_banked_array dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .bank_sel(bank_sel),
    .row_wr_v(row_wr_v), .row_rd_v(row_rd_v), .bl_v(bl_v), .blb_v(blb_v)
  );

  always #5 clk = ~clk;

  function automatic int n_high_rows();
    int n = 0;
    for (int r = 0; r < 16; r++) begin
      if (row_rd_v[r] == V_HI) n++;
      if (row_wr_v[r] == V_HI) n++;
    end
    return n;
  endfunction

  task automatic check_idle_outputs(input string tag);
    total++;
    if (ready !== 1'b1 || rvalid !== 1'b0 || bank_sel !== 2'b00) begin
      bad++;
      $display("FAIL %s ctrl: ready=%b rvalid=%b bank_sel=%b want 1 0 00", tag, ready, rvalid, bank_sel);
    end
    for (int r = 0; r < 16; r++) begin
      total++;
      if (row_rd_v[r] != V_LO || row_wr_v[r] != V_LO) begin
        bad++;
        $display("FAIL %s row%0d: rd=%f wr=%f want 0.0", tag, r, row_rd_v[r], row_wr_v[r]);
      end
    end
    for (int c = 0; c < 8; c++) begin
      total++;
      if (bl_v[c] != V_HI || blb_v[c] != V_HI) begin
        bad++;
        $display("FAIL %s col%0d: bl=%f blb=%f want 1.5", tag, c, bl_v[c], blb_v[c]);
      end
    end
  endtask

  // Caller is 1 time unit after a rising edge with the DUT idle.
  task automatic do_read(input logic [4:0] a, input logic [7:0] exp, input string tag);
    logic [1:0] sel;
    sel = a[4] ? 2'b10 : 2'b01;
    req = 1'b1; we = 1'b0; addr = a; wdata = 8'h00;
    @(posedge clk); #1;
    req = 1'b0;
    total++;
    if (ready !== 1'b0 || bank_sel !== sel || n_high_rows() != 0) begin
      bad++;
      $display("FAIL %s prech: ready=%b bank_sel=%b rows=%0d want 0 %b 0", tag, ready, bank_sel, n_high_rows(), sel);
    end
    for (int c = 0; c < 8; c++) begin
      total++;
      if (bl_v[c] != V_HI || blb_v[c] != V_HI) begin
        bad++;
        $display("FAIL %s prech col%0d: bl=%f blb=%f want 1.5", tag, c, bl_v[c], blb_v[c]);
      end
    end
    @(posedge clk); #1;
    total++;
    if (row_rd_v[a[3:0]] != V_HI || n_high_rows() != 1 || rvalid !== 1'b0) begin
      bad++;
      $display("FAIL %s rwl: row=%f high=%0d rvalid=%b want 1.5 1 0", tag, row_rd_v[a[3:0]], n_high_rows(), rvalid);
    end
    for (int c = 0; c < 8; c++) begin
      total++;
      if (bl_v[c] != (exp[c] ? V_HI : V_HALF) || blb_v[c] != (exp[c] ? V_HALF : V_HI)) begin
        bad++;
        $display("FAIL %s rwl col%0d: bl=%f blb=%f bit=%b", tag, c, bl_v[c], blb_v[c], exp[c]);
      end
    end
    @(posedge clk); #1;
    total++;
    if (rvalid !== 1'b1 || rdata !== exp || n_high_rows() != 0 || bank_sel !== sel) begin
      bad++;
      $display("FAIL %s sense: rvalid=%b rdata=%h rows=%0d want 1 %h 0", tag, rvalid, rdata, n_high_rows(), exp);
    end
    @(posedge clk); #1;
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL %s hold: rdata=%h want %h", tag, rdata, exp);
    end
    check_idle_outputs(tag);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d, input string tag);
    logic [1:0] sel;
    sel = a[4] ? 2'b10 : 2'b01;
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; wdata = ~d;
    total++;
    if (ready !== 1'b0 || bank_sel !== sel || n_high_rows() != 0 || rvalid !== 1'b0) begin
      bad++;
      $display("FAIL %s wdrive: ready=%b bank_sel=%b rows=%0d rvalid=%b", tag, ready, bank_sel, n_high_rows(), rvalid);
    end
    for (int c = 0; c < 8; c++) begin
      total++;
      if (bl_v[c] != (d[c] ? V_HI : V_LO) || blb_v[c] != (d[c] ? V_LO : V_HI)) begin
        bad++;
        $display("FAIL %s wdrive col%0d: bl=%f blb=%f bit=%b", tag, c, bl_v[c], blb_v[c], d[c]);
      end
    end
    @(posedge clk); #1;
    total++;
    if (row_wr_v[a[3:0]] != V_HI || n_high_rows() != 1 || rvalid !== 1'b0 || bank_sel !== sel) begin
      bad++;
      $display("FAIL %s wwl: row=%f high=%0d rvalid=%b bank_sel=%b", tag, row_wr_v[a[3:0]], n_high_rows(), rvalid, bank_sel);
    end
    @(posedge clk); #1;
    check_idle_outputs(tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #12;
    total++;
    if (rdata !== 8'h00) begin
      bad++;
      $display("FAIL reset rdata: got %h want 00", rdata);
    end
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_zero();
    do_read(5'h00, 8'h00, "read_zero");
  endtask

  task automatic test_write_read();
    do_write(5'h13, 8'hA5, "wr_a5");
    do_read(5'h13, 8'hA5, "rd_a5");
  endtask

  task automatic test_bank_isolation();
    do_write(5'h03, 8'hFF, "wr_b0");
    do_read(5'h13, 8'hA5, "rd_b1_iso");
    do_read(5'h03, 8'hFF, "rd_b0");
  endtask

  task automatic test_wordlines();
    for (int r = 0; r < 16; r++) begin
      do_write({1'b1, 4'(r)}, 8'(r * 13 + 1), "wl_wr");
    end
    for (int r = 0; r < 16; r++) begin
      do_read({1'b1, 4'(r)}, 8'(r * 13 + 1), "wl_rd");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] model [0:31];
    logic [4:0] m_addr;
    logic [7:0] m_data;
    logic [7:0] m_rdata;
    int ms;
    int reads, pulses;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    ms = 0; reads = 0; pulses = 0;
    m_addr = '0; m_data = '0; m_rdata = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      req   = (cyc < 44);
      we    = cyc[0];
      addr  = 5'(cyc * 7);
      wdata = 8'(cyc * 37 + 5);
      if (rvalid === 1'b1) pulses++;
      total++;
      if (ready !== (ms == 0) || rvalid !== (ms == 3) || (ms == 3 && rdata !== m_rdata)) begin
        bad++;
        $display("FAIL b2b cyc%0d: ready=%b rvalid=%b rdata=%h model_state=%0d want_rdata=%h", cyc, ready, rvalid, rdata, ms, m_rdata);
      end
      @(posedge clk); #1;
      case (ms)
        0: if (req) begin
             m_addr = addr; m_data = wdata;
             if (we) ms = 4;
             else begin ms = 1; reads++; end
           end
        1: ms = 2;
        2: begin m_rdata = model[m_addr]; ms = 3; end
        3: ms = 0;
        4: ms = 5;
        default: begin model[m_addr] = m_data; ms = 0; end
      endcase
    end
    req = 1'b0;
    total++;
    if (pulses != reads || reads == 0) begin
      bad++;
      $display("FAIL b2b count: rvalid pulses=%0d reads accepted=%0d", pulses, reads);
    end
    for (int k = 0; k < 6; k++) begin
      do_read(5'(k * 7 + 7), model[5'(k * 7 + 7)], "b2b_readback");
    end
  endtask

  task automatic test_reset_mid();
    req = 1'b1; we = 1'b1; addr = 5'h05; wdata = 8'h3C;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    total++;
    if (row_wr_v[5] != V_HI) begin
      bad++;
      $display("FAIL rst_mid wwl: row5=%f want 1.5", row_wr_v[5]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (rdata !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid rdata: got %h want 00", rdata);
    end
    check_idle_outputs("rst_mid");
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(5'h05, 8'h00, "rst_mid_rd");
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_write_read();
    test_bank_isolation();
    test_wordlines();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
